sd_cmd_responder: RTL and testbench

//  Card-side end of the SD CMD line: deserialises 48-bit host command frames, checks framing/CRC7,

---
 rtl/sd_cmd_responder.sv | 199 +++++++++++++++++++
 tb/tb_sd_cmd_responder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD line endpoint: receives 48-bit host commands, answers with R1-style frames.
// Define SD_CMD_RESP_CRC_CHECK_EN to reject received frames whose CRC7 field is wrong.
module sd_cmd_responder #(
  parameter int NCR_MIN      = 2,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic        CLK_SD_card,
  input  logic        reset,
  input  logic        cmd_from_host,
  input  logic        resp_valid,
  input  logic [31:0] resp_status,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        crc_error,
  output logic        frame_error,
  output logic        cmd_to_host,
  output logic        cmd_to_host_oe,
  output logic        busy
);

  localparam int MAXC = (NCR_MIN > RESP_TIMEOUT) ? NCR_MIN : RESP_TIMEOUT;
  localparam int WW   = $clog2(MAXC + 2);

  localparam logic [WW-1:0] NCR_W = WW'(NCR_MIN);
  localparam logic [WW-1:0] TMO_W = WW'(RESP_TIMEOUT);
  localparam logic [5:0]    LAST  = 6'd47;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    CHECK,
    WAIT_RESP,
    TX
  } state_t;

  state_t        state;
  logic [47:0]   rxsr;
  logic [5:0]    bitcnt;
  logic [WW-1:0] wcnt;
  logic          have_st;
  logic [31:0]   st_q;
  logic [47:0]   txsr;
  logic [5:0]    tcnt;

  logic          rx_dir;
  logic          rx_end;
  logic [5:0]    rx_idx;
  logic [31:0]   rx_arg;
  logic [6:0]    rx_crc;
  logic [6:0]    rx_calc;
  logic          crc_bad;
  logic          got;
  logic [31:0]   st_n;
  logic [39:0]   resp40;
  logic [47:0]   tx_frame;

  // Serial CRC7, generator x^7+x^3+1, zero initial value, MSB first.
  function automatic logic [6:0] crc7_calc(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  assign rx_dir  = rxsr[46];
  assign rx_end  = rxsr[0];
  assign rx_idx  = rxsr[45:40];
  assign rx_arg  = rxsr[39:8];
  assign rx_crc  = rxsr[7:1];
  assign rx_calc = crc7_calc(rxsr[47:8]);

`ifdef SD_CMD_RESP_CRC_CHECK_EN
  assign crc_bad = (rx_crc != rx_calc);
`else
  logic unused_crc;
  assign crc_bad    = 1'b0;
  assign unused_crc = ^{rx_crc, rx_calc};
`endif

  // Response payload: the first offered status wins, even on the same edge it arrives.
  always_comb begin
    got      = have_st | resp_valid;
    st_n     = have_st ? st_q : resp_status;
    resp40   = {2'b00, cmd_index, st_n};
    tx_frame = {resp40, crc7_calc(resp40), 1'b1};
  end

  // Command receive, check, response wait and transmit sequencing with registered outputs.
  always_ff @(posedge CLK_SD_card) begin
    if (!reset) begin
      state          <= IDLE;
      rxsr           <= '0;
      bitcnt         <= '0;
      wcnt           <= '0;
      have_st        <= 1'b0;
      st_q           <= '0;
      txsr           <= '0;
      tcnt           <= '0;
      cmd_valid      <= 1'b0;
      cmd_index      <= '0;
      cmd_arg        <= '0;
      crc_error      <= 1'b0;
      frame_error    <= 1'b0;
      cmd_to_host    <= 1'b1;
      cmd_to_host_oe <= 1'b0;
      busy           <= 1'b0;
    end else begin
      cmd_valid   <= 1'b0;
      crc_error   <= 1'b0;
      frame_error <= 1'b0;
      unique case (state)
        IDLE: begin
          cmd_to_host    <= 1'b1;
          cmd_to_host_oe <= 1'b0;
          if (!cmd_from_host) begin
            rxsr   <= {rxsr[46:0], 1'b0};
            bitcnt <= 6'd1;
            state  <= RX;
            busy   <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        RX: begin
          rxsr <= {rxsr[46:0], cmd_from_host};
          if (bitcnt == LAST) begin
            state <= CHECK;
          end else begin
            bitcnt <= bitcnt + 6'd1;
          end
        end
        CHECK: begin
          bitcnt <= '0;
          if (!rx_dir || !rx_end) begin
            frame_error <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else if (crc_bad) begin
            crc_error <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end else begin
            cmd_valid <= 1'b1;
            cmd_index <= rx_idx;
            cmd_arg   <= rx_arg;
            wcnt      <= {{(WW-1){1'b0}}, 1'b1};
            have_st   <= 1'b0;
            state     <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (got && wcnt >= NCR_W) begin
            cmd_to_host    <= tx_frame[47];
            cmd_to_host_oe <= 1'b1;
            txsr           <= {tx_frame[46:0], 1'b0};
            tcnt           <= '0;
            have_st        <= 1'b0;
            state          <= TX;
          end else if (!got && wcnt >= TMO_W) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (!have_st && resp_valid) begin
              have_st <= 1'b1;
              st_q    <= resp_status;
            end
            if (wcnt != '1) begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        TX: begin
          if (tcnt == LAST) begin
            cmd_to_host    <= 1'b1;
            cmd_to_host_oe <= 1'b0;
            state          <= IDLE;
            busy           <= 1'b0;
          end else begin
            cmd_to_host <= txsr[47];
            txsr        <= {txsr[46:0], 1'b0};
            tcnt        <= tcnt + 6'd1;
          end
        end
        default: begin
          state          <= IDLE;
          cmd_to_host    <= 1'b1;
          cmd_to_host_oe <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Scoreboard bench for sd_cmd_responder: random host commands, queued expectations,
// a card-logic responder process and an independent output monitor.
module tb_sd_cmd_responder;

  localparam int NCR_MIN      = 2;
  localparam int RESP_TIMEOUT = 64;

`ifdef SD_CMD_RESP_CRC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_from_host = 1'b1;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_status = '0;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        crc_error;
  logic        frame_error;
  logic        cmd_to_host;
  logic        cmd_to_host_oe;
  logic        busy;

  always #5 clk = ~clk;

  sd_cmd_responder #(
    .NCR_MIN(NCR_MIN),
    .RESP_TIMEOUT(RESP_TIMEOUT)
  ) dut (
    .CLK_SD_card(clk),
    .reset(reset),
    .cmd_from_host(cmd_from_host),
    .resp_valid(resp_valid),
    .resp_status(resp_status),
    .cmd_valid(cmd_valid),
    .cmd_index(cmd_index),
    .cmd_arg(cmd_arg),
    .crc_error(crc_error),
    .frame_error(frame_error),
    .cmd_to_host(cmd_to_host),
    .cmd_to_host_oe(cmd_to_host_oe),
    .busy(busy)
  );

  typedef struct {
    int        kind;
    bit [5:0]  idx;
    bit [31:0] arg;
  } ev_t;

  typedef struct {
    bit [47:0] f;
    int        gap;
  } resp_t;

  typedef struct {
    bit        en;
    int        d;
    bit [31:0] st;
  } plan_t;

  ev_t   exp_ev[$];
  resp_t exp_resp[$];
  plan_t plan[$];

  int        n_tests = 0;
  int        n_fail = 0;
  bit [5:0]  h_idx = '0;
  bit [31:0] h_arg = '0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic bit [6:0] ref_crc(input bit [39:0] m);
    bit [46:0] v;
    v = {m, 7'd0};
    for (int i = 46; i >= 7; i--) begin
      if (v[i]) v = v ^ (47'h89 << (i - 7));
    end
    return v[6:0];
  endfunction

  // Card logic: answers each accepted command after a planned delay.
  initial begin
    plan_t p;
    forever begin
      @(negedge clk);
      if (cmd_valid && plan.size() > 0) begin
        p = plan.pop_front();
        if (p.en) begin
          repeat (p.d) @(negedge clk);
          resp_valid  = 1'b1;
          resp_status = p.st;
          @(negedge clk);
          if (p.d == 0) begin
            resp_status = ~p.st;
            @(negedge clk);
          end
          resp_valid  = 1'b0;
          resp_status = $urandom;
        end
      end
    end
  end

  // Output monitor: pops expectations whenever the DUT signals something.
  int        cyc = 0;
  int        last_cv = 0;
  bit        in_tx = 1'b0;
  int        nbits = 0;
  bit [47:0] acc;
  resp_t     cur;
  bit        have_cur = 1'b0;

  always @(negedge clk) begin
    ev_t e;
    cyc++;
    if (cmd_valid || crc_error || frame_error) begin
      chk("pulse_expected", exp_ev.size() > 0, 1);
      if (exp_ev.size() > 0) begin
        e = exp_ev.pop_front();
        chk("pulse_kind", {cmd_valid, crc_error, frame_error},
            (e.kind == 0) ? 3'b100 : (e.kind == 1) ? 3'b010 : 3'b001);
        chk("cmd_index", cmd_index, e.idx);
        chk("cmd_arg", cmd_arg, e.arg);
      end
      if (cmd_valid) last_cv = cyc;
    end
    if (in_tx) begin
      if (cmd_to_host_oe) begin
        if (nbits == 48) begin
          chk("oe_len", nbits + 1, 48);
          in_tx = 1'b0;
        end else begin
          acc = {acc[46:0], cmd_to_host};
          nbits++;
        end
      end else begin
        in_tx = 1'b0;
        if (nbits == 48) begin
          if (have_cur) chk("resp_frame", acc, cur.f);
        end else if (reset !== 1'b0) begin
          chk("oe_len", nbits, 48);
        end
      end
    end else if (cmd_to_host_oe) begin
      in_tx = 1'b1;
      nbits = 1;
      acc   = {47'd0, cmd_to_host};
      chk("resp_expected", exp_resp.size() > 0, 1);
      have_cur = exp_resp.size() > 0;
      if (have_cur) begin
        cur = exp_resp.pop_front();
        chk("resp_gap", cyc - last_cv, cur.gap);
      end
    end
    if (!cmd_to_host_oe) chk("line_idle_high", cmd_to_host, 1);
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_cmd(input bit [5:0] idx, input bit [31:0] arg,
                          input bit [6:0] cx, input bit dirb, input bit endb,
                          input bit en, input int d, input bit wait_done);
    bit [39:0] m;
    bit [47:0] f;
    bit [31:0] st;
    ev_t       e;
    plan_t     p;
    resp_t     r;
    m = {1'b0, dirb, idx, arg};
    f = {m, ref_crc(m) ^ cx, endb};
    if (!dirb || !endb) begin
      e = '{2, h_idx, h_arg};
    end else if (cx != 0 && CHK) begin
      e = '{1, h_idx, h_arg};
    end else begin
      h_idx = idx;
      h_arg = arg;
      e     = '{0, idx, arg};
      st    = $urandom;
      p     = '{en, d, st};
      plan.push_back(p);
      if (en) begin
        r.f   = {2'b00, idx, st, ref_crc({2'b00, idx, st}), 1'b1};
        r.gap = (d + 1 > NCR_MIN) ? d + 1 : NCR_MIN;
        exp_resp.push_back(r);
      end
    end
    exp_ev.push_back(e);
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk);
      cmd_from_host = f[i];
    end
    @(negedge clk);
    cmd_from_host = 1'b1;
    if (wait_done) wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int        n;
    int        ty;
    bit [5:0]  idx;
    bit [31:0] arg;
    bit [6:0]  cx;

    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_index", cmd_index, 0);
    chk("rst_cmd_arg", cmd_arg, 0);
    chk("rst_errors", {crc_error, frame_error}, 0);
    chk("rst_oe", cmd_to_host_oe, 0);
    chk("rst_line", cmd_to_host, 1);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    send_cmd(6'd0, 32'h0, 7'h00, 1'b1, 1'b1, 1'b1, 0, 1'b1);
    send_cmd(6'd8, 32'h1AA, 7'h00, 1'b1, 1'b1, 1'b1, 10, 1'b1);
    send_cmd(6'd8, 32'h1AA, 7'h07, 1'b1, 1'b1, 1'b1, 3, 1'b1);
    chk("crc_test_oe", cmd_to_host_oe, 0);
    send_cmd(6'd17, 32'h12345678, 7'h00, 1'b0, 1'b1, 1'b1, 0, 1'b1);
    send_cmd(6'd18, 32'h9ABCDEF0, 7'h00, 1'b1, 1'b0, 1'b1, 0, 1'b1);
    chk("frame_test_oe", cmd_to_host_oe, 0);

    send_cmd(6'd55, $urandom, 7'h00, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    n = 0;
    while (!cmd_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cv_seen", cmd_valid, 1);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_busy_cycles", n, RESP_TIMEOUT);
    chk("timeout_oe", cmd_to_host_oe, 0);
    repeat (2) @(negedge clk);
    send_cmd(6'd0, 32'h0, 7'h00, 1'b1, 1'b1, 1'b1, 0, 1'b1);

    for (int k = 0; k < 24; k++) begin
      ty  = $urandom_range(0, 5);
      idx = 6'($urandom);
      arg = $urandom;
      cx  = (ty == 3) ? 7'($urandom_range(1, 127)) : 7'h00;
      send_cmd(idx, arg, cx, ty != 4, ty != 5,
               $urandom_range(0, 7) != 0, $urandom_range(0, 12), 1'b1);
    end

    send_cmd(6'd17, $urandom, 7'h00, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    n = 0;
    while (!cmd_to_host_oe && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_tx_started", cmd_to_host_oe, 1);
    repeat (20) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_tx_oe", cmd_to_host_oe, 0);
    chk("rst_tx_line", cmd_to_host, 1);
    chk("rst_tx_busy", busy, 0);
    repeat (2) @(negedge clk);
    h_idx = '0;
    h_arg = '0;
    chk("rst_tx_index", cmd_index, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    send_cmd(6'd0, 32'h0, 7'h00, 1'b1, 1'b1, 1'b1, 0, 1'b1);

    repeat (5) @(negedge clk);
    chk("ev_queue_drained", exp_ev.size(), 0);
    chk("resp_queue_drained", exp_resp.size(), 0);
    chk("plan_queue_drained", plan.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
